// File: rtl/mips_pkg.sv
// Shared definitions for the execute-stage shift unit: operation encodings,
// sequencer states and the default datapath width.
package mips_pkg;

    localparam int LARGURA_PADRAO       = 32;
    localparam int LARGURA_SHAMT_PADRAO = 5;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } operacao_e;

    typedef enum logic [1:0] {
        OCIOSO     = 2'b00,
        DESLOCANDO = 2'b01,
        CONCLUIDO  = 2'b10
    } estado_e;

endpackage

// File: rtl/passo_deslocamento.sv
// One-bit shift/rotate step; the sequencer applies it once per clock.
module passo_deslocamento
    import mips_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic [LARGURA-1:0] registrador_i,
    input  operacao_e          operacao_i,
    output logic [LARGURA-1:0] proximo_o
);

    always_comb begin
        proximo_o = registrador_i;
        case (operacao_i)
            OP_SRL:  proximo_o = {1'b0, registrador_i[LARGURA-1:1]};
            OP_SRA:  proximo_o = {registrador_i[LARGURA-1], registrador_i[LARGURA-1:1]};
            OP_SLL:  proximo_o = {registrador_i[LARGURA-2:0], 1'b0};
            OP_ROR:  proximo_o = {registrador_i[0], registrador_i[LARGURA-1:1]};
            default: proximo_o = registrador_i;
        endcase
    end

endmodule

// File: rtl/deslocador_sequencial.sv
// Iterative shifter: one bit position per clock, start/ready handshake,
// result published only on completion.
//
// state      | meaning
// OCIOSO     | idle; accepts inicio (including the pronto cycle)
// DESLOCANDO | one step per edge until the latched count reaches zero
// CONCLUIDO  | final busy cycle; its exit edge publishes dado_out and pronto
module deslocador_sequencial
    import mips_pkg::*;
#(
    parameter int LARGURA       = LARGURA_PADRAO,
    parameter int LARGURA_SHAMT = LARGURA_SHAMT_PADRAO
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inicio,
    input  logic [1:0]               operacao,
    input  logic [LARGURA_SHAMT-1:0] shamt,
    input  logic [LARGURA-1:0]       dado_in,
    output logic [LARGURA-1:0]       dado_out,
    output logic                     pronto,
    output logic                     ocupado
);

    localparam logic [LARGURA_SHAMT-1:0] CONT_UM = LARGURA_SHAMT'(1);

    estado_e                  estado_q, estado_d;
    operacao_e                op_q, op_d;
    logic [LARGURA-1:0]       reg_q, reg_d;
    logic [LARGURA-1:0]       dado_out_q, dado_out_d;
    logic [LARGURA_SHAMT-1:0] cont_q, cont_d;
    logic                     pronto_q, pronto_d;
    logic [LARGURA-1:0]       passo;

    passo_deslocamento #(
        .LARGURA (LARGURA)
    ) u_passo (
        .registrador_i (reg_q),
        .operacao_i    (op_q),
        .proximo_o     (passo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            op_q       <= OP_SRL;
            reg_q      <= '0;
            dado_out_q <= '0;
            cont_q     <= '0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            op_q       <= op_d;
            reg_q      <= reg_d;
            dado_out_q <= dado_out_d;
            cont_q     <= cont_d;
            pronto_q   <= pronto_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        op_d       = op_q;
        reg_d      = reg_q;
        dado_out_d = dado_out_q;
        cont_d     = cont_q;
        pronto_d   = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    reg_d    = dado_in;
                    op_d     = operacao_e'(operacao);
                    cont_d   = shamt;
                    estado_d = (shamt != '0) ? DESLOCANDO : CONCLUIDO;
                end
            end
            DESLOCANDO: begin
                reg_d  = passo;
                cont_d = cont_q - CONT_UM;
                if (cont_q == CONT_UM) begin
                    estado_d = CONCLUIDO;
                end
            end
            CONCLUIDO: begin
                dado_out_d = reg_q;
                pronto_d   = 1'b1;
                estado_d   = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // pronto is only raised on the edge back to OCIOSO, so it can never overlap ocupado
    always_comb begin
        dado_out = dado_out_q;
        pronto   = pronto_q;
        ocupado  = (estado_q != OCIOSO);
    end

endmodule

// File: tb/tb_deslocador_sequencial.sv
// Self-checking bench for deslocador_sequencial: directed vector table,
// hand-written corner sequences and randomized ops against an arithmetic model.
module tb_deslocador_sequencial;

    logic        clk;
    logic        reset;
    logic        inicio;
    logic [1:0]  operacao;
    logic [4:0]  shamt;
    logic [31:0] dado_in;
    logic [31:0] dado_out;
    logic        pronto;
    logic        ocupado;

    int checks = 0;
    int errors = 0;

    deslocador_sequencial dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .operacao (operacao),
        .shamt    (shamt),
        .dado_in  (dado_in),
        .dado_out (dado_out),
        .pronto   (pronto),
        .ocupado  (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  s;
        logic [31:0] d;
        logic [31:0] esperado;
        bit          embaralhar;
    } vetor_t;

    function automatic logic [31:0] modelo(input logic [1:0] op, input logic [4:0] s,
                                           input logic [31:0] d);
        int n;
        n = int'(s);
        case (op)
            2'd0: return d >> n;
            2'd1: return $unsigned($signed(d) >>> n);
            2'd2: return d << n;
            default: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
    endfunction

    task automatic chk(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: obtido %h esperado %h", nome, obtido, esperado);
        end
    endtask

    // Called just after the start edge E0; returns the index of the edge after
    // which pronto was seen (64 = timed out), leaving the bench at that negedge.
    task automatic aguarda_pronto(input bit embaralhar, input logic [31:0] anterior,
                                  output int n, output bit occ_ok, output bit hold_ok);
        n       = 0;
        occ_ok  = 1'b1;
        hold_ok = 1'b1;
        @(negedge clk);
        while (!pronto && n < 64) begin
            if (ocupado !== 1'b1) occ_ok = 1'b0;
            if (dado_out !== anterior) hold_ok = 1'b0;
            if (embaralhar) begin
                dado_in  = $urandom;
                shamt    = 5'($urandom);
                operacao = 2'($urandom);
                inicio   = 1'($urandom);
            end else begin
                inicio = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        inicio = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [4:0] s, input logic [31:0] d,
                          input logic [31:0] esperado, input bit embaralhar);
        int          n;
        bit          occ_ok, hold_ok, extra;
        logic [31:0] anterior;
        anterior = dado_out;
        inicio   = 1'b1;
        operacao = op;
        shamt    = s;
        dado_in  = d;
        @(posedge clk);
        aguarda_pronto(embaralhar, anterior, n, occ_ok, hold_ok);
        chk("latencia", n, int'(s) + 1);
        chk("resultado", dado_out, esperado);
        chk("ocupado_durante", {31'b0, occ_ok}, 32'd1);
        chk("dado_out_retido", {31'b0, hold_ok}, 32'd1);
        chk("exclusao_ocupado", {31'b0, ocupado}, 32'd0);
        extra = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            extra |= pronto;
        end
        chk("pronto_extra", {31'b0, extra}, 32'd0);
        chk("dado_out_mantido", dado_out, esperado);
    endtask

    vetor_t tabela[$];

    initial begin
        int          n;
        bit          occ_ok, hold_ok, visto;
        logic [1:0]  rop;
        logic [4:0]  rs;
        logic [31:0] rd;

        tabela.push_back('{2'd0, 5'd4,  32'hF000_0000, 32'h0F00_0000, 1'b0});
        tabela.push_back('{2'd1, 5'd8,  32'h8000_0010, 32'hFF80_0000, 1'b0});
        tabela.push_back('{2'd1, 5'd8,  32'h4000_0010, 32'h0040_0000, 1'b0});
        tabela.push_back('{2'd2, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b0});
        tabela.push_back('{2'd0, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        tabela.push_back('{2'd3, 5'd4,  32'h0000_000F, 32'hF000_0000, 1'b1});
        tabela.push_back('{2'd2, 5'd1,  32'h8000_0001, 32'h0000_0002, 1'b0});
        tabela.push_back('{2'd3, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b1});
        tabela.push_back('{2'd1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0});

        reset    = 1'b1;
        inicio   = 1'b0;
        operacao = 2'd0;
        shamt    = 5'd0;
        dado_in  = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_dado_out", dado_out, 32'd0);
        chk("reset_pronto", {31'b0, pronto}, 32'd0);
        chk("reset_ocupado", {31'b0, ocupado}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (tabela[i]) begin
            run_op(tabela[i].op, tabela[i].s, tabela[i].d, tabela[i].esperado, tabela[i].embaralhar);
        end

        // back-to-back: second op started in the pronto cycle of the first
        inicio = 1'b1; operacao = 2'd0; shamt = 5'd1; dado_in = 32'h10;
        @(posedge clk);
        aguarda_pronto(1'b0, dado_out, n, occ_ok, hold_ok);
        chk("b2b_primeiro", dado_out, 32'h8);
        inicio = 1'b1; operacao = 2'd2; shamt = 5'd2; dado_in = 32'h1;
        @(posedge clk);
        aguarda_pronto(1'b0, 32'h8, n, occ_ok, hold_ok);
        chk("b2b_latencia", n, 32'd3);
        chk("b2b_retido", {31'b0, hold_ok}, 32'd1);
        chk("b2b_ocupado", {31'b0, occ_ok}, 32'd1);
        chk("b2b_segundo", dado_out, 32'h4);
        @(negedge clk);

        // reset in the middle of a shamt=10 operation
        inicio = 1'b1; operacao = 2'd0; shamt = 5'd10; dado_in = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_meio_dado_out", dado_out, 32'd0);
        chk("rst_meio_ocupado", {31'b0, ocupado}, 32'd0);
        chk("rst_meio_pronto", {31'b0, pronto}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        visto = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            visto |= pronto;
        end
        chk("rst_meio_sem_pronto", {31'b0, visto}, 32'd0);
        run_op(2'd1, 5'd3, 32'h8000_0000, 32'hF000_0000, 1'b0);

        for (int k = 0; k < 30; k++) begin
            rop = 2'($urandom_range(0, 3));
            rs  = 5'($urandom_range(0, 31));
            rd  = $urandom;
            run_op(rop, rs, rd, modelo(rop, rs, rd), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
